// File: rtl/spi_pkg.sv
// Shared constants for the SPI master/slave pair: FSM encoding,
// byte width and the slave frame opcodes used by bench and firmware drivers.
package spi_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  localparam int SPI_BYTE_W = 8;

  localparam logic [7:0] OP_REG_WR  = 8'h02;
  localparam logic [7:0] OP_REG_RD  = 8'h03;
  localparam logic [7:0] OP_FIFO_RD = 8'h0B;

endpackage

// File: rtl/spi_clk_tick.sv
// SPI half-period timer: tick every CLK_DIV enabled cycles,
// restarted whenever the owning FSM changes state.
module spi_clk_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == W'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Byte-oriented SPI mode-0 master, one CS frame of xfer_len bytes per start.
// Define SPI_MASTER_LOOPBACK_EN to sample spi_mosi instead of spi_miso.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int LEN_W    = 8,
  parameter int CS_SETUP = 1,
  parameter int CS_GAP   = 2
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] xfer_len,
  input  logic [7:0]       tx_data,
  output logic             tx_rd,
  output logic [7:0]       rx_data,
  output logic             rx_dval,
  output logic             busy,
  output logic             done,
  output logic             spi_ncs,
  output logic             spi_clk,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       tcnt_q, tcnt_d;
  logic [2:0]       bit_q, bit_d;
  logic             ph_q, ph_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_dval_q, rx_dval_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ncs_q, ncs_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             tx_rd_c;
  logic             tick;
  logic             smp;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign smp = mosi_q;
`else
  assign smp = spi_miso;
`endif

  spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .en    (state_q != IDLE),
    .clr   (state_d != state_q),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    tcnt_d    = tcnt_q;
    bit_d     = bit_q;
    ph_d      = ph_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    rx_dval_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ncs_d     = ncs_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    tx_rd_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (xfer_len != '0)) begin
          rem_d   = xfer_len;
          ncs_d   = 1'b0;
          tx_sh_d = tx_data;
          mosi_d  = tx_data[7];
          tx_rd_c = 1'b1;
          busy_d  = 1'b1;
          tcnt_d  = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          if (tcnt_q == 8'(CS_SETUP - 1)) begin
            tcnt_d  = '0;
            bit_d   = '0;
            ph_d    = 1'b0;
            sclk_d  = 1'b0;
            state_d = SHIFT;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end
      SHIFT: begin
        if (tick && !ph_q) begin
          sclk_d  = 1'b1;
          ph_d    = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], smp};
        end else if (tick) begin
          sclk_d = 1'b0;
          ph_d   = 1'b0;
          bit_d  = bit_q + 3'd1;
          if (bit_q != 3'd7) begin
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
            mosi_d  = tx_sh_q[6];
          end else begin
            // Byte boundary: hand off rx byte and reload with no idle clock
            rx_data_d = rx_sh_q;
            rx_dval_d = 1'b1;
            rem_d     = rem_q - LEN_W'(1);
            if (rem_q != LEN_W'(1)) begin
              tx_sh_d = tx_data;
              mosi_d  = tx_data[7];
              tx_rd_c = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          ncs_d   = 1'b1;
          tcnt_d  = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          if (tcnt_q == 8'(CS_GAP - 1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      tcnt_q    <= '0;
      bit_q     <= '0;
      ph_q      <= 1'b0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      rx_dval_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ncs_q     <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      tcnt_q    <= tcnt_d;
      bit_q     <= bit_d;
      ph_q      <= ph_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      rx_dval_q <= rx_dval_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ncs_q     <= ncs_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
    end
  end

  assign tx_rd    = tx_rd_c & rst_n;
  assign rx_data  = rx_data_q;
  assign rx_dval  = rx_dval_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_ncs  = ncs_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomized bench for spi_master_ctrl against a frame-level reference
// model (expected bytes, bit stream, pulse counts and frame latency).
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int CLK_DIV  = 2;
  localparam int LEN_W    = 8;
  localparam int CS_SETUP = 1;
  localparam int CS_GAP   = 2;

  logic             sys_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] xfer_len = '0;
  logic [7:0]       tx_data;
  logic             tx_rd;
  logic [7:0]       rx_data;
  logic             rx_dval;
  logic             busy;
  logic             done;
  logic             spi_ncs;
  logic             spi_clk;
  logic             spi_mosi;
  logic             spi_miso;

  spi_master_ctrl #(
    .CLK_DIV(CLK_DIV), .LEN_W(LEN_W),
    .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .start    (start),
    .xfer_len (xfer_len),
    .tx_data  (tx_data),
    .tx_rd    (tx_rd),
    .rx_data  (rx_data),
    .rx_dval  (rx_dval),
    .busy     (busy),
    .done     (done),
    .spi_ncs  (spi_ncs),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 sys_clk = ~sys_clk;

  logic [7:0] txb [16];
  logic [7:0] misob [16];
  logic [7:0] regs [256];
  int tx_idx = 0, tx_base = 0;
  int bitpos = 0, bitbase = 0, cur_len = 0;
  int done_n = 0, txrd_n = 0, ncs_rise_n = 0;
  int rel;
  logic mosi_q [$];
  logic [7:0] rx_q [$];
  int n_chk = 0, n_pass = 0;

  assign tx_data = txb[4'(tx_idx - tx_base)];

  // Slave-side model: MSB first, next bit presented after each rising edge
  always_comb begin
    rel = bitpos - bitbase;
    spi_miso = 1'b0;
    if (rel >= 0 && rel < 8 * cur_len)
      spi_miso = misob[rel[6:3]][3'd7 - rel[2:0]];
  end

  always @(posedge sys_clk) begin
    if (tx_rd) begin
      tx_idx <= tx_idx + 1;
      txrd_n <= txrd_n + 1;
    end
    if (done) done_n <= done_n + 1;
    if (rx_dval) rx_q.push_back(rx_data);
  end

  always @(posedge spi_clk) begin
    mosi_q.push_back(spi_mosi);
    bitpos <= bitpos + 1;
  end

  always @(posedge spi_ncs) ncs_rise_n <= ncs_rise_n + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic run_frame(input int len, input bit extra_start);
    int b_rd, b_done, b_ncs, cyc;
    logic [7:0] mb, er;
    rx_q.delete();
    mosi_q.delete();
    @(negedge sys_clk);
    bitbase = bitpos;
    tx_base = tx_idx;
    b_rd = txrd_n;
    b_done = done_n;
    b_ncs = ncs_rise_n;
    cur_len = len;
    xfer_len = LEN_W'(len);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    cyc = 1;
    chk("busy_set", busy, 1);
    while (!done && cyc < 5000) begin
      start = extra_start && (cyc == 10);
      @(negedge sys_clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", cyc, CLK_DIV * (CS_SETUP + 16 * len + 1 + CS_GAP) + 1);
    chk("busy_drop", busy, 0);
    repeat (40) @(negedge sys_clk);
    chk("busy_after", busy, 0);
    chk("done_cnt", done_n - b_done, 1);
    chk("tx_rd_cnt", txrd_n - b_rd, len);
    chk("rx_cnt", rx_q.size(), len);
    chk("rises", mosi_q.size(), 8 * len);
    chk("ncs_rises", ncs_rise_n - b_ncs, 1);
    chk("ncs_idle", spi_ncs, 1);
    for (int i = 0; i < len; i++) begin
      mb = '0;
      for (int k = 0; k < 8; k++)
        if (8 * i + k < mosi_q.size()) mb = {mb[6:0], mosi_q[8 * i + k]};
`ifdef SPI_MASTER_LOOPBACK_EN
      er = txb[i];
`else
      er = misob[i];
`endif
      chk("mosi_byte", mb, txb[i]);
      if (i < rx_q.size()) chk("rx_byte", rx_q[i], er);
    end
    mb = txb[len - 1];
    chk("mosi_hold", spi_mosi, mb[0]);
  endtask

  initial begin
    int len, b_done, b_rd, cyc;
    for (int i = 0; i < 16; i++) begin
      txb[i] = '0;
      misob[i] = '0;
    end
    for (int i = 0; i < 256; i++) regs[i] = '0;
    #23;
    chk("rst_ncs", spi_ncs, 1);
    chk("rst_clk", spi_clk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rxd", rx_data, 0);
    chk("rst_dval", rx_dval, 0);
    chk("rst_txrd", tx_rd, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    txb[0] = 8'hA5;
    misob[0] = 8'h3C;
    run_frame(1, 1'b0);

    txb[0] = 8'h01; txb[1] = 8'h80; txb[2] = 8'hFF;
    for (int i = 0; i < 3; i++) misob[i] = 8'($urandom);
    run_frame(3, 1'b0);

    b_done = done_n;
    b_rd = txrd_n;
    xfer_len = '0;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (10) @(negedge sys_clk);
    chk("zl_busy", busy, 0);
    chk("zl_done", done_n - b_done, 0);
    chk("zl_txrd", txrd_n - b_rd, 0);

    for (int i = 0; i < 2; i++) begin
      txb[i] = 8'($urandom);
      misob[i] = 8'($urandom);
    end
    run_frame(2, 1'b1);

    for (int i = 0; i < 3; i++) begin
      txb[i] = 8'($urandom);
      misob[i] = 8'($urandom);
    end
    @(negedge sys_clk);
    bitbase = bitpos;
    tx_base = tx_idx;
    b_done = done_n;
    cur_len = 3;
    xfer_len = 8'd3;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    cyc = 0;
    while (bitpos - bitbase < 12 && cyc < 2000) begin
      @(negedge sys_clk);
      cyc++;
    end
    chk("mid_reached", (bitpos - bitbase) >= 12, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_ncs", spi_ncs, 1);
    chk("ar_clk", spi_clk, 0);
    chk("ar_busy", busy, 0);
    chk("ar_mosi", spi_mosi, 0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (80) @(negedge sys_clk);
    chk("ar_nodone", done_n - b_done, 0);
    chk("ar_rxd", rx_data, 0);

    for (int i = 0; i < 3; i++) begin
      txb[i] = 8'($urandom);
      misob[i] = 8'($urandom);
    end
    run_frame(3, 1'b0);

    txb[0] = 8'h00; txb[1] = 8'h55; txb[2] = 8'hAA; txb[3] = 8'hC3;
    for (int i = 0; i < 4; i++) misob[i] = 8'hFF;
    run_frame(4, 1'b0);

    txb[0] = OP_REG_WR; txb[1] = 8'h02; txb[2] = 8'h5A;
    for (int i = 0; i < 3; i++) misob[i] = 8'h00;
    run_frame(3, 1'b0);
    regs[txb[1]] = txb[2];
    txb[0] = OP_REG_RD; txb[1] = 8'h02; txb[2] = 8'h00;
    misob[0] = 8'h00; misob[1] = 8'h00; misob[2] = regs[8'h02];
    run_frame(3, 1'b0);
`ifndef SPI_MASTER_LOOPBACK_EN
    if (rx_q.size() == 3) chk("reg_rd", rx_q[2], 8'h5A);
    else chk("reg_rd_cnt", rx_q.size(), 3);
`endif

    for (int f = 0; f < 6; f++) begin
      len = int'($urandom_range(1, 5));
      for (int i = 0; i < len; i++) begin
        txb[i] = 8'($urandom);
        misob[i] = 8'($urandom);
      end
      run_frame(len, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Byte-oriented SPI master (mode 0: CPOL=0, CPHA=0, MSB first) that drives spi_ncs, spi_clk and spi_mosi, and samples spi_miso.
- Board-side counterpart of the spi_slave_ctrl top. Used in the companion test/controller chip and in the system bench to issue register and FIFO transactions.
- Performs one chip-select frame of xfer_len bytes per start pulse.
- Pulls transmit bytes through a show-ahead read strobe and pushes received bytes out with a valid pulse.

Parameters:
- CLK_DIV, 2: SPI half-period in sys_clk cycles (>=1); spi_clk period = 2*CLK_DIV cycles.
- LEN_W, 8: width of xfer_len; up to 2^LEN_W-1 bytes per frame.
- CS_SETUP, 1: half-periods from spi_ncs falling to the first spi_clk rise.
- CS_GAP, 2: minimum half-periods spi_ncs stays high after a frame before busy drops.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle frame request; sampled only in IDLE.
- xfer_len  in  LEN_W  byte count, captured on start.
- tx_data  in  8  show-ahead next byte to send.
- tx_rd  out  1  one-cycle pulse when tx_data is consumed.
- rx_data  out  8  last received byte.
- rx_dval  out  1  one-cycle pulse when rx_data is updated.
- busy  out  1  high from start acceptance until the end of the CS gap.
- done  out  1  one-cycle pulse at the end of the frame.
- spi_ncs  out  1  chip select, active low.
- spi_clk  out  1  SPI clock.
- spi_mosi  out  1  master out.
- spi_miso  in  1  master in.

Behaviour:
- Reset values:
  - spi_ncs=1, spi_clk=0, spi_mosi=0.
  - tx_rd=0, rx_data=0, rx_dval=0, busy=0, done=0.
  - State machine in IDLE; all counters 0.
- Half-period tick:
  - Counter runs 0..CLK_DIV-1 outside IDLE; tick asserts when count==CLK_DIV-1.
  - The counter is cleared on entry to each state.
- IDLE:
  - start with xfer_len!=0: capture the length, drive spi_ncs=0, load the shift register from tx_data, pulse tx_rd, drive spi_mosi with bit 7, set busy in the next cycle, then go to SETUP.
  - start with xfer_len==0: ignored. No busy, no done.
- SETUP: wait CS_SETUP ticks, then go to SHIFT with spi_clk=0.
- SHIFT, alternating ticks:
  - Rising tick: spi_clk=1; sample spi_miso into the rx shift register LSB.
  - Falling tick: spi_clk=0; bit counter increments.
  - If bits remain in the byte, shift and present the next bit on spi_mosi.
- Byte boundary (falling tick of bit 0):
  - rx_data updates and rx_dval pulses in the same cycle; the remaining-byte count decrements.
  - If bytes remain: the next byte loads from tx_data with a tx_rd pulse in the same cycle, and SHIFT continues with no idle clock.
  - Otherwise: go to HOLD.
- HOLD: one tick with spi_clk=0, then spi_ncs=1 and go to GAP.
- GAP: CS_GAP ticks, then done pulses, busy drops in the same cycle, and the block returns to IDLE.
- start while busy: ignored, never queued.
- tx_rd count per frame = xfer_len exactly; rx_dval count per frame = xfer_len exactly.
- Frame length in sys_clk cycles: CLK_DIV*(CS_SETUP + 16*xfer_len + 1 + CS_GAP) + 1 (start cycle).
- spi_mosi holds its last bit between bytes and after the frame; it returns to 0 only on reset.
- Reset asserted mid-frame:
  - All outputs take their reset values immediately (spi_ncs high asynchronously).
  - The partial byte is discarded, and done is not pulsed.

Optional Feature:
- SPI_MASTER_LOOPBACK_EN defined: the internal sample source is spi_mosi instead of spi_miso, so each rx byte equals the tx byte sent. spi_miso is unused, and pin outputs are unchanged.
- Undefined: sampling comes from spi_miso as described above.

Decomposition:
- Package spi_pkg:
  - State encoding localparams: IDLE, SETUP, SHIFT, HOLD, GAP.
  - SPI_BYTE_W=8.
  - Shared opcode constants for the slave frame format (register write, register read, FIFO read) used by both the bench and firmware-model drivers.
- One sub-module, spi_clk_tick: the half-period counter. Inputs: enable, clear. Output: tick.

Test Plan:
- Single byte, CLK_DIV=2, xfer_len=1, tx_data=8'hA5, miso driven by a model returning 8'h3C:
  - mosi bits 1,0,1,0,0,1,0,1 on rising edges; rx_data=8'h3C with one rx_dval.
  - done at 2*(1+16+1+2)+1=41 cycles after start.
- Three-byte frame, tx 8'h01, 8'h80, 8'hFF:
  - Exactly 3 tx_rd and 3 rx_dval pulses; spi_ncs low continuously.
  - 24 spi_clk rises with no gap between bytes.
- start with xfer_len=0, then start while busy:
  - First: no busy, no done.
  - Second: the frame completes normally with one done and no second frame.
- rst_n asserted during bit 4 of byte 2:
  - spi_ncs=1 and spi_clk=0 asynchronously; no done.
  - The next start runs a clean full frame.
- SPI_MASTER_LOOPBACK_EN build, 4 bytes 8'h00, 8'h55, 8'hAA, 8'hC3 with spi_miso tied to 1: rx bytes equal the tx bytes.
- End-to-end with spi_slave_ctrl: register write addr 8'h02 data 8'h5A, then a read of the same address returns 8'h5A on rx_data.
